// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_addsub
//  Description : Pipelined carry-lookahead adder/subtractor, one group per stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSTG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0) begin : g_param_check
        $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP");
    end

    // Every carry is a flat sum of products over g/p and the group carry-in.
    function automatic logic [GROUP:0] f_carries(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             c0);
        logic [GROUP:0] c;
        logic           t;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            t = c0;
            for (int j = 0; j <= i; j++) t = t & p[j];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) t = t & p[m];
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    logic             w_adv;
    logic             r_in_v;
    logic [WIDTH-1:0] r_in_a;
    logic [WIDTH-1:0] r_in_b;
    logic             r_in_c;

    // Operand capture; B and the carry-in are already adjusted for subtraction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_v <= 1'b0;
            r_in_a <= '0;
            r_in_b <= '0;
            r_in_c <= 1'b0;
        end else if (w_adv) begin
            r_in_v <= in_valid;
            r_in_a <= a;
            r_in_b <= b ^ {WIDTH{sub}};
            r_in_c <= cin ^ sub;
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        localparam int HI_W = WIDTH - (k + 1) * GROUP;

        logic [GROUP-1:0]         w_ga;
        logic [GROUP-1:0]         w_gb;
        logic [GROUP-1:0]         w_p;
        logic [GROUP-1:0]         w_g;
        logic [GROUP-1:0]         w_s;
        logic [GROUP:0]           w_c;
        logic                     w_gc;
        logic                     w_v_in;
        logic [(k+1)*GROUP-1:0]   w_s_nxt;
        logic [(k+1)*GROUP-1:0]   r_s;
        logic                     r_v;
        logic                     r_c;

        if (k == 0) begin : g_src
            assign w_ga    = r_in_a[GROUP-1:0];
            assign w_gb    = r_in_b[GROUP-1:0];
            assign w_gc    = r_in_c;
            assign w_v_in  = r_in_v;
            assign w_s_nxt = w_s;
        end else begin : g_src
            assign w_ga    = g_stage[k-1].g_hold.r_a[GROUP-1:0];
            assign w_gb    = g_stage[k-1].g_hold.r_b[GROUP-1:0];
            assign w_gc    = g_stage[k-1].r_c;
            assign w_v_in  = g_stage[k-1].r_v;
            assign w_s_nxt = {w_s, g_stage[k-1].r_s};
        end

        assign w_p = w_ga ^ w_gb;
        assign w_g = w_ga & w_gb;
        assign w_c = f_carries(w_p, w_g, w_gc);
        assign w_s = w_p ^ w_c[GROUP-1:0];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_v_in;
                r_c <= w_c[GROUP];
                r_s <= w_s_nxt;
            end
        end

        // Operand bits of groups not yet resolved travel alongside the partial sum.
        if (HI_W > 0) begin : g_hold
            logic [HI_W-1:0] w_a_up;
            logic [HI_W-1:0] w_b_up;
            logic [HI_W-1:0] r_a;
            logic [HI_W-1:0] r_b;

            if (k == 0) begin : g_up
                assign w_a_up = r_in_a[WIDTH-1:GROUP];
                assign w_b_up = r_in_b[WIDTH-1:GROUP];
            end else begin : g_up
                assign w_a_up = g_stage[k-1].g_hold.r_a[HI_W+GROUP-1:GROUP];
                assign w_b_up = g_stage[k-1].g_hold.r_b[HI_W+GROUP-1:GROUP];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_up;
                    r_b <= w_b_up;
                end
            end
        end

        if (k == NSTG - 1) begin : g_out
            logic r_ovf;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_c[GROUP] ^ w_c[GROUP-1];
                end
            end
        end
    end

    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = g_stage[NSTG-1].r_v;
    assign sum       = g_stage[NSTG-1].r_s;
    assign cout      = g_stage[NSTG-1].r_c;
    assign ovf       = g_stage[NSTG-1].g_out.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_addsub
//  Description : Directed and streaming checks of cla_pipe_addsub (16-bit, 4-bit groups).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_addsub;
    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] a         = '0;
    logic [15:0] b         = '0;
    logic        cin       = 1'b0;
    logic        sub       = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] q[$];
    logic [17:0] held = '0;
    logic        stall_prev = 1'b0;

    cla_pipe_addsub #(.WIDTH(16), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum}, overflow from operand/result signs.
    function automatic logic [17:0] refm(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
        logic [15:0] ye;
        logic        ce;
        logic [16:0] f;
        logic        ov;
        ye = s ? ~y : y;
        ce = s ? ~c : c;
        f  = {1'b0, x} + {1'b0, ye} + {16'b0, ce};
        ov = (x[15] == ye[15]) && (f[15] != x[15]);
        return {ov, f};
    endfunction

    task automatic directed(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic c, input logic s, input logic [15:0] es,
                            input logic ec, input logic eo);
        int lat;
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        cin       = c;
        sub       = s;
        out_ready = 1'b1;
        #2;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
        sub      = 1'($urandom);
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        tick();
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    task automatic step(input logic v, input logic rdy);
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        logic        s;
        logic [17:0] e;
        x = 16'($urandom);
        y = 16'($urandom);
        c = 1'($urandom);
        s = 1'($urandom);
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = c;
        sub       = s;
        out_ready = rdy;
        #2;
        if (stall_prev)
            chk("stall_hold", 32'({out_valid, ovf, cout, sum}), 32'({1'b1, held}));
        if (out_valid === 1'b1 && rdy) begin
            chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stream_result", 32'({ovf, cout, sum}), 32'(e));
            end
        end
        held       = {ovf, cout, sum};
        stall_prev = (out_valid === 1'b1) && !rdy;
        if (v && in_ready === 1'b1) q.push_back(refm(x, y, c, s));
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        directed("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_7fff_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub_8000_1",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("sub_5_7",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_5_2_bin",  16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        directed("add_cin",      16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        directed("sub_0_0",      16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        directed("add_8000_x2",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        stall_prev = 1'b0;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        chk("stream_all_returned", 32'(q.size()), 32'd0);
        chk("stream_idle", 32'(out_valid), 32'd0);

        for (int i = 0; i < 150; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        chk("bp_all_returned", 32'(q.size()), 32'd0);
        chk("bp_idle", 32'(out_valid), 32'd0);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        rst_n      = 1'b1;
        stall_prev = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        directed("post_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
